// File: rtl/ex_mem_datapath.sv
// EX/MEM datapath slice: ALU control decode, combinational ALU and a
// word-addressed data memory with combinational load and clocked store.
module ex_mem_datapath #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  ex_op,
    input  logic [5:0]  ex_funct,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    input  logic [5:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_NOP = 3'b011;
    localparam logic [2:0] C_NOR = 3'b100;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_SLT = 3'b111;

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0]          r_mem [DEPTH];
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_unused;

    always_comb begin
        alu_ctrl = C_NOP;
        case (ex_op)
            OP_LW, OP_SW, OP_ADDI: alu_ctrl = C_ADD;
            OP_BEQ:                alu_ctrl = C_SUB;
            OP_RTYPE: begin
                case (ex_funct)
                    6'd32:   alu_ctrl = C_ADD;
                    6'd34:   alu_ctrl = C_SUB;
                    6'd36:   alu_ctrl = C_AND;
                    6'd37:   alu_ctrl = C_OR;
                    6'd39:   alu_ctrl = C_NOR;
                    6'd42:   alu_ctrl = C_SLT;
                    default: alu_ctrl = C_NOP;
                endcase
            end
            default: alu_ctrl = C_NOP;
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            C_AND:   alu_out = alu_a & alu_b;
            C_OR:    alu_out = alu_a | alu_b;
            C_ADD:   alu_out = alu_a + alu_b;
            C_SUB:   alu_out = alu_a - alu_b;
            C_NOR:   alu_out = ~(alu_a | alu_b);
            C_SLT:   alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == 32'd0);

    // Byte offset and high address bits are dropped, so accesses wrap.
    assign w_index  = mem_addr[ADDR_BITS+1:2];
    assign w_unused = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_op == OP_SW) begin
            r_mem[w_index] <= mem_wdata;
        end
    end

    // Load path reads the array directly, so a same-cycle store is seen only after the edge.
    assign mem_rdata = (mem_op == OP_LW) ? r_mem[w_index] : 32'd0;

endmodule

// File: tb/tb_ex_mem_datapath.sv
// Self-checking bench for ex_mem_datapath: directed vectors plus random
// ALU and memory traffic compared against a behavioural model.
module tb_ex_mem_datapath;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] RT   = 6'b000000;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  ex_op, ex_funct, mem_op;
    logic [31:0] alu_a, alu_b, alu_out, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  alu_ctrl;
    logic        alu_zero;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [256];

    ex_mem_datapath #(.ADDR_BITS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .ex_op     (ex_op),
        .ex_funct  (ex_funct),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected control code from the opcode/funct table.
    function automatic logic [2:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn);
        if (op == LW || op == SW || op == ADDI) return 3'b010;
        if (op == BEQ) return 3'b110;
        if (op != RT) return 3'b011;
        if (fn == 6'd32) return 3'b010;
        if (fn == 6'd34) return 3'b110;
        if (fn == 6'd36) return 3'b000;
        if (fn == 6'd37) return 3'b001;
        if (fn == 6'd39) return 3'b100;
        if (fn == 6'd42) return 3'b111;
        return 3'b011;
    endfunction

    // Expected result from the instruction's meaning, using integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        ua = a; ub = b;
        sa = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        if (op == LW || op == SW || op == ADDI) return 32'((ua + ub) % 64'h1_0000_0000);
        if (op == BEQ) return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
        if (op != RT) return 32'd0;
        case (fn)
            6'd32: return 32'((ua + ub) % 64'h1_0000_0000);
            6'd34: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            6'd36: return a & b;
            6'd37: return a | b;
            6'd39: return ~(a | b);
            6'd42: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % 256);
    endfunction

    // Model the store/reset effect of the coming edge, then advance past it.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        end else if (mem_op == SW) begin
            model_mem[widx(mem_addr)] = mem_wdata;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic alu_check(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        ex_op = op; ex_funct = fn; alu_a = a; alu_b = b;
        #1;
        e = ref_alu(op, fn, a, b);
        chk({tag, "_ctrl"}, {29'd0, alu_ctrl}, {29'd0, ref_ctrl(op, fn)});
        chk({tag, "_out"},  alu_out, e);
        chk({tag, "_zero"}, {31'd0, alu_zero}, {31'd0, (e == 32'd0)});
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr);
        mem_op = LW; mem_addr = addr;
        #1;
        chk(tag, mem_rdata, model_mem[widx(addr)]);
    endtask

    initial begin
        logic [5:0]  op_tab [6];
        logic [5:0]  fn_tab [8];
        logic [31:0] a, b, addr;
        op_tab[0] = LW; op_tab[1] = SW; op_tab[2] = BEQ;
        op_tab[3] = ADDI; op_tab[4] = RT; op_tab[5] = 6'b001101;
        fn_tab[0] = 6'd32; fn_tab[1] = 6'd34; fn_tab[2] = 6'd36; fn_tab[3] = 6'd37;
        fn_tab[4] = 6'd39; fn_tab[5] = 6'd42; fn_tab[6] = 6'd8;  fn_tab[7] = 6'd0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'hxxxx_xxxx;

        reset = 1'b1; mem_op = SW; mem_addr = 32'h8; mem_wdata = 32'h5555_5555;
        ex_op = RT; ex_funct = 6'd32; alu_a = 32'd3; alu_b = 32'd4;
        // ALU is live while reset is held.
        alu_check("alu_in_reset", RT, 6'd32, 32'd3, 32'd4);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = $urandom;
            load_check("post_reset_zero", addr);
            chk("post_reset_zero_abs", mem_rdata, 32'd0);
        end
        load_check("post_reset_sw_suppressed", 32'h8);

        alu_check("add_wrap",  RT, 6'd32, 32'h7FFF_FFFF, 32'd1);
        chk("add_wrap_abs", alu_out, 32'h8000_0000);
        alu_check("beq_equal", BEQ, 6'd0, 32'h1234, 32'h1234);
        chk("beq_zero_abs", {31'd0, alu_zero}, 32'd1);
        alu_check("slt_neg",   RT, 6'd42, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg_abs", alu_out, 32'd1);
        alu_check("and", RT, 6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and_abs", alu_out, 32'hF000_F000);
        alu_check("or",  RT, 6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("or_abs", alu_out, 32'hFFF0_FFF0);
        alu_check("nor", RT, 6'd39, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("nor_abs", alu_out, 32'h000F_000F);
        alu_check("unk_funct", RT, 6'd8, 32'h1234_5678, 32'h1);
        chk("unk_funct_ctrl_abs", {29'd0, alu_ctrl}, 32'd3);
        alu_check("sub_borrow", RT, 6'd34, 32'd0, 32'd1);
        chk("sub_borrow_abs", alu_out, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = (i % 5 == 0) ? a : $urandom;
            alu_check("rand_alu", op_tab[$urandom_range(5)], fn_tab[$urandom_range(7)], a, b);
        end

        mem_op = SW; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        tick();
        load_check("lw_0x10", 32'h10);
        chk("lw_0x10_abs", mem_rdata, 32'hDEAD_BEEF);
        load_check("lw_0x410_wrap", 32'h410);
        chk("lw_0x410_abs", mem_rdata, 32'hDEAD_BEEF);
        load_check("lw_0x13_offset", 32'h13);
        load_check("lw_0x14", 32'h14);
        chk("lw_0x14_abs", mem_rdata, 32'd0);

        mem_op = SW; mem_addr = 32'h20; mem_wdata = 32'hCAFE_F00D;
        #1;
        chk("rdw_before_edge", mem_rdata, 32'd0);
        tick();
        load_check("rdw_after_edge", 32'h20);
        chk("rdw_after_edge_abs", mem_rdata, 32'hCAFE_F00D);

        mem_op = SW; mem_addr = 32'h40; mem_wdata = 32'h0BAD_F00D;
        tick();
        mem_op = ADDI; mem_addr = 32'h40; mem_wdata = 32'h1111_2222;
        #1;
        chk("addi_rdata_zero", mem_rdata, 32'd0);
        tick();
        load_check("addi_no_write", 32'h40);
        chk("addi_no_write_abs", mem_rdata, 32'h0BAD_F00D);

        for (int i = 0; i < 80; i++) begin
            mem_op = op_tab[$urandom_range(3)];
            mem_addr = {$urandom_range(15) == 0 ? $urandom : 32'($urandom_range(255) * 4 + $urandom_range(3))};
            mem_wdata = $urandom;
            #1;
            chk("rand_mem_rdata", mem_rdata,
                (mem_op == LW) ? model_mem[widx(mem_addr)] : 32'd0);
            tick();
        end

        reset = 1'b1; mem_op = SW; mem_addr = 32'h30; mem_wdata = 32'h1357_9BDF;
        tick();
        reset = 1'b0;
        load_check("sw_in_reset", 32'h30);
        chk("sw_in_reset_abs", mem_rdata, 32'd0);
        load_check("reset_clears_prior", 32'h10);
        chk("reset_clears_prior_abs", mem_rdata, 32'd0);
        load_check("reset_clears_0x40", 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_datapath.md
EX_MEM_DATAPATH -- requirements
Module: ex_mem_datapath

Interface
REQ-001 Parameter: ADDR_BITS, default 8, data-memory word-address width (2**ADDR_BITS 32-bit words).
REQ-002 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: ex_op  input  6  opcode of the instruction in EX.
REQ-005 Port: ex_funct  input  6  funct field [5:0] of the EX instruction.
REQ-006 Port: alu_a  input  32  ALU operand A (already forwarded).
REQ-007 Port: alu_b  input  32  ALU operand B (already forwarded or immediate).
REQ-008 Port: alu_ctrl  output  3  decoded ALU control.
REQ-009 Port: alu_out  output  32  ALU result.
REQ-010 Port: alu_zero  output  1  high when alu_out == 0.
REQ-011 Port: mem_op  input  6  opcode of the instruction in MEM.
REQ-012 Port: mem_addr  input  32  byte address for data memory.
REQ-013 Port: mem_wdata  input  32  store data.
REQ-014 Port: mem_rdata  output  32  load data.

Function
REQ-015 Opcodes: LW=100011, SW=101011, BEQ=000100, ADDI=001000, R-type=000000.
REQ-016 alu_ctrl is combinational: LW, SW, ADDI -> 010; BEQ -> 110; R-type by funct: 32 -> 010, 34 -> 110, 36 -> 000, 37 -> 001, 39 -> 100, 42 -> 111; any other funct or opcode -> 011.
REQ-017 alu_out is combinational from alu_ctrl, alu_a and alu_b: 000 AND; 001 OR; 010 A+B mod 2**32; 110 A-B mod 2**32; 100 NOR; 111 signed compare, result 1 if A<B else 0; 011 result 0.
REQ-018 No overflow flag; carries and borrows out of bit 31 are discarded.
REQ-019 Data memory is 2**ADDR_BITS x 32 bits, indexed by mem_addr[ADDR_BITS+1:2].
REQ-020 mem_addr[1:0] and the bits above ADDR_BITS+1 are ignored, so addresses wrap modulo memory size.
REQ-021 Read is combinational: mem_rdata = mem[index] whenever mem_op == LW, otherwise 0.
REQ-022 Write occurs on the rising clock edge when mem_op == SW and reset is low: mem[index] <= mem_wdata.
REQ-023 Read-during-write to the same index: mem_rdata shows the old word in that cycle and the new word after the edge.
REQ-024 No other opcode modifies memory.
REQ-025 There is no internal pipelining; latency is 0 cycles for ALU and load, and 1 edge for store.

Reset
REQ-026 While reset is high at a rising edge, every memory word is set to 0 and any SW in that cycle is suppressed (reset has priority).
REQ-027 After reset, with mem_op = LW, mem_rdata = 0 for every address.
REQ-028 alu_ctrl, alu_out and alu_zero are combinational, unaffected by reset, and depend only on current inputs.
REQ-029 Reset asserted mid-operation discards all prior stores from the next edge onward.

Verification
REQ-030 R-type funct 32, A=0x7FFFFFFF, B=1 -> alu_ctrl=010, alu_out=0x80000000, alu_zero=0.
REQ-031 BEQ with A=B=0x1234 -> alu_ctrl=110, alu_out=0, alu_zero=1; funct 42 with A=0xFFFFFFFF, B=1 -> alu_out=1.
REQ-032 Funct 36/37/39 with A=0xF0F0F0F0, B=0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x000F000F; unknown funct 8 -> alu_ctrl=011, alu_out=0.
REQ-033 Reset, then SW to addr 0x10 with data 0xDEADBEEF; next cycle LW from addr 0x10 -> 0xDEADBEEF; LW from 0x410 (ADDR_BITS=8) -> 0xDEADBEEF (wrap); LW from 0x14 -> 0.
REQ-034 Same-cycle SW and LW to 0x20 (old value 0) -> mem_rdata=0 before the edge and new data after it; SW with reset high -> location stays 0.
REQ-035 mem_op = ADDI with a stored address -> mem_rdata=0 and memory unchanged.
